// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the emu_ram data RAM wrapper: one request in flight, alignment and funct3 checks,
// single-cycle RAM strobe, load extension. Optional statistics counters are enabled with `define LSU_STATS_EN.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [2:0]            ram_rwtyp,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [31:0]           stat_loads,
    output logic [31:0]           stat_stores,
    output logic [31:0]           stat_errs
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    lat_we_q, lat_we_d;
    logic [2:0]              lat_f3_q, lat_f3_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [2:0]              ram_rwtyp_q, ram_rwtyp_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_data_q, ram_data_d;
    logic                    ram_wren_q, ram_wren_d;
    logic                    ram_rden_q, ram_rden_d;

    // Request is rejected for an unsupported funct3 or a misaligned halfword/word address.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic illegal;
        logic misal;
        if (we) begin
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        end else begin
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                        f3 == 3'b100 || f3 == 3'b101);
        end
        misal = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
        return illegal || misal;
    endfunction

    // RAM returns the selected lanes zero-extended; signed loads replicate the top bit here.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] q,
                                                          input logic [2:0] f3);
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){q[7]}}, q[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){q[15]}}, q[15:0]};
            default: return q;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lat_we_q    <= 1'b0;
            lat_f3_q    <= 3'b000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ram_rwtyp_q <= 3'b000;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_wren_q  <= 1'b0;
            ram_rden_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_we_q    <= lat_we_d;
            lat_f3_q    <= lat_f3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_rwtyp_q <= ram_rwtyp_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_wren_q  <= ram_wren_d;
            ram_rden_q  <= ram_rden_d;
        end
    end

    // Next state and next registered outputs; RAM strobes default low so they last one cycle.
    always_comb begin
        state_d     = state_q;
        lat_we_d    = lat_we_q;
        lat_f3_d    = lat_f3_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_rwtyp_d = ram_rwtyp_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_wren_d  = 1'b0;
        ram_rden_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_we_d = req_we;
                    lat_f3_d = req_funct3;
                    if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = ISSUE;
                        ram_rwtyp_d = req_funct3;
                        ram_addr_d  = req_addr;
                        ram_data_d  = req_wdata;
                        ram_wren_d  = req_we;
                        ram_rden_d  = !req_we;
                    end
                end
            end
            ISSUE: begin
                if (lat_we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = extend_load(ram_q, lat_f3_q);
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready_d = (state_d == IDLE);

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_rwtyp = ram_rwtyp_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_wren  = ram_wren_q;
    assign ram_rden  = ram_rden_q;

`ifdef LSU_STATS_EN
    logic        accept_c;
    logic        issue_load_c;
    logic        issue_store_c;
    logic        accept_err_c;
    logic [31:0] stat_loads_q;
    logic [31:0] stat_stores_q;
    logic [31:0] stat_errs_q;

    assign accept_c      = (state_q == IDLE) && req_valid;
    assign issue_load_c  = accept_c && (state_d == ISSUE) && !req_we;
    assign issue_store_c = accept_c && (state_d == ISSUE) && req_we;
    assign accept_err_c  = accept_c && (state_d == RESP);

    // Free-running event counters; natural 32-bit wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_loads_q  <= 32'd0;
            stat_stores_q <= 32'd0;
            stat_errs_q   <= 32'd0;
        end else begin
            if (issue_load_c) begin
                stat_loads_q <= stat_loads_q + 32'd1;
            end
            if (issue_store_c) begin
                stat_stores_q <= stat_stores_q + 32'd1;
            end
            if (accept_err_c) begin
                stat_errs_q <= stat_errs_q + 32'd1;
            end
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`else
    assign stat_loads  = 32'd0;
    assign stat_stores = 32'd0;
    assign stat_errs   = 32'd0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural emu_ram model (lane-shifting writes, zero-extended reads).
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  ram_rwtyp;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic        ram_rden;
    logic [31:0] ram_q;
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_rwtyp  (ram_rwtyp),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q),
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errs  (stat_errs)
    );

    // RAM model: word array, byte lanes selected by rwtyp[1:0] and addr[1:0].
    logic [31:0] mem [0:255];

    function automatic logic [31:0] ram_merge(input logic [31:0] w, input logic [1:0] typ,
                                              input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (typ)
            2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ram_extract(input logic [31:0] w, input logic [1:0] typ,
                                                input logic [1:0] a);
        case (typ)
            2'b00:   return {24'd0, w[{a, 3'b000} +: 8]};
            2'b01:   return {16'd0, w[{a[1], 4'b0000} +: 16]};
            default: return w;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        ram_q <= 32'd0;
        if (ram_wren) mem[ram_addr[9:2]] <= ram_merge(mem[ram_addr[9:2]], ram_rwtyp[1:0], ram_addr[1:0], ram_data);
        if (ram_rden) ram_q <= ram_extract(mem[ram_addr[9:2]], ram_rwtyp[1:0], ram_addr[1:0]);
    end

    // Strobe monitor, sampled mid-cycle.
    int wren_cnt, rden_cnt, both_cnt;
    always @(negedge clk) begin
        if (ram_wren) wren_cnt <= wren_cnt + 1;
        if (ram_rden) rden_cnt <= rden_cnt + 1;
        if (ram_wren && ram_rden) both_cnt <= both_cnt + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold, input logic err,
                                 input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.hold = hold;
        v.exp_err = err; v.exp_rdata = rdata;
        v.exp_lat = err ? 1 : (we ? 2 : 3);
        return v;
    endfunction

    // One full transaction starting and ending at a negedge in IDLE.
    task automatic run_req(input vec_t v, input string tag);
        int lat;
        wren_cnt = 0; rden_cnt = 0; both_cnt = 0;
        chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s hold%0d rsp_valid", tag, i), 32'(rsp_valid), 32'd1);
            chk($sformatf("%s hold%0d rsp_rdata", tag, i), rsp_rdata, v.exp_rdata);
            chk($sformatf("%s hold%0d req_ready", tag, i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " post req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " post rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " post rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, " wren pulses"}, 32'(wren_cnt), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        chk({tag, " rden pulses"}, 32'(rden_cnt), (!v.we && !v.exp_err) ? 32'd1 : 32'd0);
        chk({tag, " wren&rden"}, 32'(both_cnt), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " ram_wren"}, 32'(ram_wren), 32'd0);
        chk({tag, " ram_rden"}, 32'(ram_rden), 32'd0);
        chk({tag, " ram_rwtyp"}, 32'(ram_rwtyp), 32'd0);
        chk({tag, " ram_addr"}, ram_addr, 32'd0);
        chk({tag, " ram_data"}, ram_data, 32'd0);
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] l, input logic [31:0] s,
                             input logic [31:0] e);
`ifdef LSU_STATS_EN
        chk({tag, " stat_loads"}, stat_loads, l);
        chk({tag, " stat_stores"}, stat_stores, s);
        chk({tag, " stat_errs"}, stat_errs, e);
`else
        chk({tag, " stat_loads"}, stat_loads, l & 32'd0);
        chk({tag, " stat_stores"}, stat_stores, s & 32'd0);
        chk({tag, " stat_errs"}, stat_errs, e & 32'd0);
`endif
    endtask

    vec_t vecs[$];

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        wren_cnt = 0; rden_cnt = 0; both_cnt = 0;

        // we, funct3, addr, wdata, hold, err, rdata
        vecs.push_back(mkv(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 3'b010, 32'h100, 32'h0,        5, 0, 32'hDEADBEEF));
        vecs.push_back(mkv(1, 3'b000, 32'h103, 32'h000000F0, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 3'b000, 32'h103, 32'h0,        0, 0, 32'hFFFFFFF0));
        vecs.push_back(mkv(0, 3'b100, 32'h103, 32'h0,        0, 0, 32'h000000F0));
        vecs.push_back(mkv(0, 3'b001, 32'h102, 32'h0,        0, 0, 32'hFFFFF0AD));
        vecs.push_back(mkv(0, 3'b101, 32'h102, 32'h0,        0, 0, 32'h0000F0AD));
        vecs.push_back(mkv(0, 3'b000, 32'h101, 32'h0,        0, 0, 32'hFFFFFFBE));
        vecs.push_back(mkv(0, 3'b010, 32'h102, 32'h0,        0, 1, 32'h0));
        vecs.push_back(mkv(1, 3'b001, 32'h101, 32'h00005555, 0, 1, 32'h0));
        vecs.push_back(mkv(1, 3'b100, 32'h100, 32'h11111111, 2, 1, 32'h0));
        vecs.push_back(mkv(0, 3'b010, 32'h100, 32'h0,        0, 0, 32'hF0ADBEEF));
        vecs.push_back(mkv(0, 3'b011, 32'h100, 32'h0,        0, 1, 32'h0));
        vecs.push_back(mkv(0, 3'b110, 32'h100, 32'h0,        0, 1, 32'h0));
        vecs.push_back(mkv(1, 3'b001, 32'h102, 32'h00001234, 0, 0, 32'h0));
        vecs.push_back(mkv(0, 3'b001, 32'h102, 32'h0,        0, 0, 32'h00001234));
        vecs.push_back(mkv(0, 3'b000, 32'h103, 32'h0,        0, 0, 32'h00000012));
        vecs.push_back(mkv(0, 3'b000, 32'h100, 32'h0,        0, 0, 32'hFFFFFFEF));
        vecs.push_back(mkv(0, 3'b100, 32'h101, 32'h0,        0, 0, 32'h000000BE));
        vecs.push_back(mkv(1, 3'b010, 32'h200, 32'hCAFEF00D, 0, 0, 32'h0));

        repeat (2) @(negedge clk);
        chk_reset_outs("in_reset");
        chk_stats("in_reset", 32'd0, 32'd0, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], $sformatf("v%0d", i));

        // Reset during ISSUE, before the edge that would write the RAM.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstA issue ram_wren", 32'(ram_wren), 32'd1);
        rstn = 1'b0;
        #1;
        chk_reset_outs("rstA");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_req(mkv(0, 3'b010, 32'h200, 32'h0, 0, 0, 32'hCAFEF00D), "rstA_lw");

        // Reset just after the ISSUE edge: the write has landed.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_reset_outs("rstB");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_req(mkv(0, 3'b010, 32'h200, 32'h0, 0, 0, 32'h12345678), "rstB_lw");

        // Reset in WAIT: load response never appears.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_reset_outs("rstW");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstW later rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstW later req_ready", 32'(req_ready), 32'd1);

        // Statistics after a fresh reset.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_stats("stats0", 32'd0, 32'd0, 32'd0);
        run_req(mkv(0, 3'b010, 32'h100, 32'h0,        0, 0, 32'h1234BEEF), "st_lw1");
        run_req(mkv(1, 3'b010, 32'h100, 32'h0BADF00D, 0, 0, 32'h0),        "st_sw");
        run_req(mkv(0, 3'b010, 32'h101, 32'h0,        0, 1, 32'h0),        "st_lwmis");
        run_req(mkv(0, 3'b010, 32'h100, 32'h0,        0, 0, 32'h0BADF00D), "st_lw2");
        chk_stats("stats1", 32'd2, 32'd1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
